// File: rtl/mips_defs.sv
// mips_defs: shared definitions for the MIPS-subset control path.
//   - opcode / funct constants and the opcode field position
//   - ALU-op, pc_src and ALU B-operand encodings
//   - state_flags_t: one-hot view of the controller state handed to ctrl_decode
//   - ctrl_word_t:   the full control word produced by ctrl_decode
package mips_defs;

  // Opcode field is instr[OP_HI:OP_LO]
  localparam int OP_HI = 31;
  localparam int OP_LO = 26;

  localparam logic [5:0] OP_RTYPE      = 6'h00;
  localparam logic [5:0] OP_LW         = 6'h23;
  localparam logic [5:0] OP_SW         = 6'h2B;
  localparam logic [5:0] OP_BEQ        = 6'h04;
  localparam logic [5:0] OP_J          = 6'h02;
  localparam logic [5:0] OP_ADDI       = 6'h08;
  localparam logic [5:0] OP_ORI        = 6'h0D;
  localparam logic [5:0] FUNCT_SYSCALL = 6'h0C;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_OR    = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  localparam logic [1:0] PC_RESET  = 2'b11;

  localparam logic [1:0] SRCB_REGB   = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  // One flag per controller state. Bit position = state index in the top
  // (rst_pc is bit 0, halt is bit 13).
  typedef struct packed {
    logic halt;
    logic i_wb;
    logic i_exec;
    logic jmp;
    logic beq;
    logic r_wb;
    logic r_exec;
    logic mem_wr;
    logic mem_wb;
    logic mem_rd;
    logic mem_addr;
    logic decode;
    logic fetch;
    logic rst_pc;
  } state_flags_t;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       ext_zero;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       halted;
  } ctrl_word_t;

  localparam int STATE_FLAGS_W = $bits(state_flags_t);
  localparam int CTRL_W        = $bits(ctrl_word_t);

  function automatic logic [5:0] get_op(input logic [31:0] ins);
    return ins[OP_HI:OP_LO];
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: purely combinational control-word generator.
// Ports:
//   st_vec    in  one-hot state flags (layout of state_flags_t)
//   opcode    in  IR opcode, only consulted in I_EXEC (ORI vs ADDI)
//   mem_ready in  memory completion, makes FETCH's ir/pc writes Mealy
//   cw_vec    out control word (layout of ctrl_word_t)
module ctrl_decode
  import mips_defs::*;
(
  input  logic [STATE_FLAGS_W-1:0] st_vec,
  input  logic [5:0]               opcode,
  input  logic                     mem_ready,
  output logic [CTRL_W-1:0]        cw_vec
);

  state_flags_t st;
  ctrl_word_t   cw;

  assign st     = st_vec;
  assign cw_vec = cw;

  // Flags are one-hot, so the independent ifs never overlap.
  always_comb begin
    cw = '0;
    if (st.rst_pc) begin
      cw.pc_write = 1'b1;
      cw.pc_src   = PC_RESET;
    end
    if (st.fetch) begin
      cw.mem_req   = 1'b1;
      cw.alu_src_b = SRCB_FOUR;
      cw.alu_op    = ALU_ADD;
      cw.pc_src    = PC_ALU;
      // IR and PC load exactly in the completion cycle
      cw.ir_write  = mem_ready;
      cw.pc_write  = mem_ready;
    end
    if (st.decode) begin
      cw.alu_src_b = SRCB_IMM_SH;
    end
    if (st.mem_addr) begin
      cw.alu_src_a = 1'b1;
      cw.alu_src_b = SRCB_IMM;
      cw.alu_op    = ALU_ADD;
    end
    if (st.mem_rd) begin
      cw.mem_req = 1'b1;
      cw.iord    = 1'b1;
    end
    if (st.mem_wb) begin
      cw.reg_write  = 1'b1;
      cw.mem_to_reg = 1'b1;
    end
    if (st.mem_wr) begin
      cw.mem_req = 1'b1;
      cw.mem_we  = 1'b1;
      cw.iord    = 1'b1;
    end
    if (st.r_exec) begin
      cw.alu_src_a = 1'b1;
      cw.alu_src_b = SRCB_REGB;
      cw.alu_op    = ALU_FUNCT;
    end
    if (st.r_wb) begin
      cw.reg_write = 1'b1;
      cw.reg_dst   = 1'b1;
    end
    if (st.beq) begin
      cw.alu_src_a     = 1'b1;
      cw.alu_src_b     = SRCB_REGB;
      cw.alu_op        = ALU_SUB;
      cw.pc_write_cond = 1'b1;
      cw.pc_src        = PC_ALUOUT;
    end
    if (st.jmp) begin
      cw.pc_write = 1'b1;
      cw.pc_src   = PC_JUMP;
    end
    if (st.i_exec) begin
      cw.alu_src_a = 1'b1;
      cw.alu_src_b = SRCB_IMM;
      if (opcode == OP_ORI) begin
        cw.alu_op   = ALU_OR;
        cw.ext_zero = 1'b1;
      end else begin
        cw.alu_op   = ALU_ADD;
      end
    end
    if (st.i_wb) begin
      cw.reg_write = 1'b1;
    end
    if (st.halt) begin
      cw.halted = 1'b1;
    end
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle control FSM for the MIPS-subset datapath.
// Sequences fetch/decode/execute/memory/writeback, stalls on mem_ready,
// counts retired fetches and halts on syscall or an unknown opcode.
// Ports:
//   clk, rst (async, active high)
//   instr, zero, mem_ready                      inputs
//   mem_req, mem_we, iord                       memory port control
//   ir_write, pc_write, pc_write_cond, pc_src   IR / PC control
//   alu_src_a, alu_src_b, alu_op, ext_zero      ALU / extender control
//   reg_write, reg_dst, mem_to_reg              register-file control
//   halted, instr_count                         status
module multicycle_ctrl
  import mips_defs::*;
#(
  parameter int RESET_PC_EN = 1
)(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        iord,
  output logic        ir_write,
  output logic        pc_write,
  output logic        pc_write_cond,
  output logic [1:0]  pc_src,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  alu_op,
  output logic        ext_zero,
  output logic        reg_write,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        halted,
  output logic [31:0] instr_count
);

  // Encoding index doubles as the bit position in state_flags_t.
  localparam logic [3:0] S_RST_PC   = 4'd0;
  localparam logic [3:0] S_FETCH    = 4'd1;
  localparam logic [3:0] S_DECODE   = 4'd2;
  localparam logic [3:0] S_MEM_ADDR = 4'd3;
  localparam logic [3:0] S_MEM_RD   = 4'd4;
  localparam logic [3:0] S_MEM_WB   = 4'd5;
  localparam logic [3:0] S_MEM_WR   = 4'd6;
  localparam logic [3:0] S_R_EXEC   = 4'd7;
  localparam logic [3:0] S_R_WB     = 4'd8;
  localparam logic [3:0] S_BEQ      = 4'd9;
  localparam logic [3:0] S_JMP      = 4'd10;
  localparam logic [3:0] S_I_EXEC   = 4'd11;
  localparam logic [3:0] S_I_WB     = 4'd12;
  localparam logic [3:0] S_HALT     = 4'd13;

  localparam logic [3:0] S_RESET = (RESET_PC_EN != 0) ? S_RST_PC : S_FETCH;

  logic [3:0]  state_reg, state_next;
  logic [31:0] count_reg;
  logic        store_reg;   // LW/SW choice latched in DECODE so MEM_ADDR ignores instr
  logic [5:0]  opcode, funct;
  logic        unused_inputs;

  assign opcode        = get_op(instr);
  assign funct         = instr[5:0];
  assign unused_inputs = ^{instr[25:6], zero};

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= S_RESET;
    else     state_reg <= state_next;
  end

  // Retired-fetch counter and store flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
      store_reg <= 1'b0;
    end else begin
      if (state_reg == S_FETCH && mem_ready) count_reg <= count_reg + 32'd1;
      if (state_reg == S_DECODE) store_reg <= (opcode == OP_SW);
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_RST_PC: state_next = S_FETCH;
      S_FETCH:  if (mem_ready) state_next = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:      state_next = (funct == FUNCT_SYSCALL) ? S_HALT : S_R_EXEC;
          OP_LW, OP_SW:  state_next = S_MEM_ADDR;
          OP_BEQ:        state_next = S_BEQ;
          OP_J:          state_next = S_JMP;
          OP_ADDI, OP_ORI: state_next = S_I_EXEC;
          default:       state_next = S_HALT;
        endcase
      end
      S_MEM_ADDR: state_next = store_reg ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   if (mem_ready) state_next = S_MEM_WB;
      S_MEM_WB:   state_next = S_FETCH;
      S_MEM_WR:   if (mem_ready) state_next = S_FETCH;
      S_R_EXEC:   state_next = S_R_WB;
      S_R_WB:     state_next = S_FETCH;
      S_BEQ:      state_next = S_FETCH;
      S_JMP:      state_next = S_FETCH;
      S_I_EXEC:   state_next = S_I_WB;
      S_I_WB:     state_next = S_FETCH;
      S_HALT:     state_next = S_HALT;
      default:    state_next = S_HALT;
    endcase
  end

  // One-hot view of the state for the decoder
  logic [STATE_FLAGS_W-1:0] state_oh;
  generate
    for (genvar gi = 0; gi < STATE_FLAGS_W; gi++) begin : g_state_oh
      assign state_oh[gi] = (state_reg == 4'(gi));
    end
  endgenerate

  logic [CTRL_W-1:0] cw_vec;
  ctrl_word_t        cw;

  ctrl_decode u_decode (
    .st_vec    (state_oh),
    .opcode    (opcode),
    .mem_ready (mem_ready),
    .cw_vec    (cw_vec)
  );

  assign cw = cw_vec;

  // Output logic: strobes are gated by rst so nothing fires while reset is held
  always_comb begin
    mem_req       = cw.mem_req       & ~rst;
    mem_we        = cw.mem_we        & ~rst;
    ir_write      = cw.ir_write      & ~rst;
    pc_write      = cw.pc_write      & ~rst;
    pc_write_cond = cw.pc_write_cond & ~rst;
    reg_write     = cw.reg_write     & ~rst;
    iord          = cw.iord;
    pc_src        = cw.pc_src;
    alu_src_a     = cw.alu_src_a;
    alu_src_b     = cw.alu_src_b;
    alu_op        = cw.alu_op;
    ext_zero      = cw.ext_zero;
    reg_dst       = cw.reg_dst;
    mem_to_reg    = cw.mem_to_reg;
    halted        = cw.halted;
    instr_count   = count_reg;
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench: the stimulus walks each instruction through the phases
// its class needs, pushing one expected output snapshot per cycle; a monitor
// on the falling edge pops and compares against the DUT outputs.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instr = 32'h0;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic        mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond;
  logic [1:0]  pc_src, alu_src_b, alu_op;
  logic        alu_src_a, ext_zero, reg_write, reg_dst, mem_to_reg, halted;
  logic [31:0] instr_count;

  always #5 clk = ~clk;

  multicycle_ctrl #(.RESET_PC_EN(1)) dut (
    .clk(clk), .rst(rst), .instr(instr), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_write(ir_write),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_src(pc_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .ext_zero(ext_zero), .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .halted(halted), .instr_count(instr_count)
  );

  typedef struct packed {
    logic mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond;
    logic [1:0] pc_src;
    logic alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic ext_zero, reg_write, reg_dst, mem_to_reg, halted;
    logic [31:0] instr_count;
  } snap_t;

  typedef struct {
    snap_t s;
    string tag;
  } exp_t;

  // Phases an instruction passes through
  localparam int P_RSTPC = 0, P_FETCH = 1, P_DECODE = 2, P_ADDR = 3, P_MRD = 4,
                 P_MWB = 5, P_MWR = 6, P_REX = 7, P_RWB = 8, P_BEQ = 9,
                 P_JMP = 10, P_IEX = 11, P_IWB = 12, P_HALT = 13;

  exp_t        exp_q[$];
  int          total = 0;
  int          bad = 0;
  logic [31:0] model_cnt = 0;
  snap_t       got;

  assign got = {mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond, pc_src,
                alu_src_a, alu_src_b, alu_op, ext_zero, reg_write, reg_dst,
                mem_to_reg, halted, instr_count};

  // Reference: what the outputs must be in one cycle of a given phase
  function automatic snap_t expect_word(input int ph, input logic [5:0] op,
                                        input logic rdy, input logic [31:0] cnt);
    snap_t w;
    w = '0;
    w.instr_count = cnt;
    case (ph)
      P_RSTPC:  begin w.pc_write = 1; w.pc_src = 2'b11; end
      P_FETCH:  begin w.mem_req = 1; w.alu_src_b = 2'b01;
                      w.ir_write = rdy; w.pc_write = rdy; end
      P_DECODE: w.alu_src_b = 2'b11;
      P_ADDR:   begin w.alu_src_a = 1; w.alu_src_b = 2'b10; end
      P_MRD:    begin w.mem_req = 1; w.iord = 1; end
      P_MWB:    begin w.reg_write = 1; w.mem_to_reg = 1; end
      P_MWR:    begin w.mem_req = 1; w.mem_we = 1; w.iord = 1; end
      P_REX:    begin w.alu_src_a = 1; w.alu_op = 2'b10; end
      P_RWB:    begin w.reg_write = 1; w.reg_dst = 1; end
      P_BEQ:    begin w.alu_src_a = 1; w.alu_op = 2'b01;
                      w.pc_write_cond = 1; w.pc_src = 2'b01; end
      P_JMP:    begin w.pc_write = 1; w.pc_src = 2'b10; end
      P_IEX:    begin w.alu_src_a = 1; w.alu_src_b = 2'b10;
                      if (op == 6'h0D) begin w.alu_op = 2'b11; w.ext_zero = 1; end end
      P_IWB:    w.reg_write = 1;
      P_HALT:   w.halted = 1;
      default:  w = '0;
    endcase
    return w;
  endfunction

  // Monitor
  always @(negedge clk) begin : monitor
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (got !== e.s) begin
        bad++;
        $display("FAIL %s: got %h want %h", e.tag, got, e.s);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] want);
    total++;
    if (actual !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, actual, want);
    end
  endtask

  // One cycle: drive inputs, queue the expectation, advance past the edge
  task automatic step(input int ph, input logic rdy, input string tag);
    exp_t e;
    mem_ready = rdy;
    zero = 1'($urandom_range(0, 1));
    e.s = expect_word(ph, instr[31:26], rdy, model_cnt);
    e.tag = tag;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  // Issue one instruction; returns 1 when it sends the unit to HALT
  task automatic run_instr(input logic [31:0] ins, input int fw, input int dw,
                           output logic went_halt);
    logic [5:0] op;
    int cyc;
    went_halt = 0;
    for (int i = 0; i < fw; i++) step(P_FETCH, 1'b0, "fetch_wait");
    step(P_FETCH, 1'b1, "fetch_done");
    instr = ins;
    model_cnt = model_cnt + 1;
    step(P_DECODE, rnd(), "decode");
    cyc = fw + 2;
    op = ins[31:26];
    case (op)
      6'h00: if (ins[5:0] == 6'h0C) went_halt = 1;
             else begin step(P_REX, rnd(), "r_exec"); step(P_RWB, rnd(), "r_wb"); cyc += 2; end
      6'h23: begin
        step(P_ADDR, rnd(), "lw_addr");
        for (int i = 0; i < dw; i++) step(P_MRD, 1'b0, "lw_wait");
        step(P_MRD, 1'b1, "lw_rd");
        step(P_MWB, rnd(), "lw_wb");
        cyc += 3 + dw;
      end
      6'h2B: begin
        step(P_ADDR, rnd(), "sw_addr");
        for (int i = 0; i < dw; i++) step(P_MWR, 1'b0, "sw_wait");
        step(P_MWR, 1'b1, "sw_wr");
        cyc += 2 + dw;
      end
      6'h04: begin step(P_BEQ, rnd(), "beq"); cyc += 1; end
      6'h02: begin step(P_JMP, rnd(), "jmp"); cyc += 1; end
      6'h08, 6'h0D: begin step(P_IEX, rnd(), "i_exec"); step(P_IWB, rnd(), "i_wb"); cyc += 2; end
      default: went_halt = 1;
    endcase
    $display("instr %h op %h cycles %0d halt %0d", ins, op, cyc, went_halt);
  endtask

  task automatic halt_cycles(input int n);
    for (int i = 0; i < n; i++) step(P_HALT, rnd(), "halt");
  endtask

  task automatic do_reset();
    rst = 1;
    for (int i = 0; i < 3; i++) begin
      mem_ready = rnd();
      @(negedge clk);
      check("rst_strobes", {26'd0, mem_req, mem_we, ir_write, pc_write, pc_write_cond, reg_write}, 32'd0);
      check("rst_count", instr_count, 32'd0);
      check("rst_halted", {31'd0, halted}, 32'd0);
    end
    @(posedge clk);
    #1;
    rst = 0;
    model_cnt = 0;
    step(P_RSTPC, rnd(), "rst_pc");
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    logic [5:0]  f;
    r = $urandom;
    case ($urandom_range(0, 6))
      0: begin
        f = 6'($urandom_range(0, 63));
        if (f == 6'h0C) f = 6'h20;
        r = {6'h00, r[25:6], f};
      end
      1: r[31:26] = 6'h23;
      2: r[31:26] = 6'h2B;
      3: r[31:26] = 6'h04;
      4: r[31:26] = 6'h02;
      5: r[31:26] = 6'h08;
      default: r[31:26] = 6'h0D;
    endcase
    return r;
  endfunction

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic h;
    int fw, dw;
    do_reset();
    // Directed sequence
    run_instr(32'h012A4020, 0, 0, h);   // add $8,$9,$10
    check("add_count", instr_count, 32'd1);
    run_instr(32'h3508FFFF, 0, 0, h);   // ori
    run_instr(32'h8D090004, 0, 3, h);   // lw, 3 wait states
    run_instr(32'hAD090008, 1, 2, h);   // sw with waits
    run_instr(32'h08000010, 0, 0, h);   // j
    run_instr(32'h1109FFFF, 0, 0, h);   // beq
    run_instr(32'hFC000000, 0, 0, h);   // illegal opcode
    check("illegal_halts", {31'd0, h}, 32'd1);
    halt_cycles(20);

    // Random program ending in syscall
    do_reset();
    for (int k = 0; k < 40; k++) begin
      fw = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      dw = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
      run_instr(rand_instr(), fw, dw, h);
    end
    run_instr({6'h00, 20'h12345, 6'h0C}, 0, 0, h);
    check("syscall_halts", {31'd0, h}, 32'd1);
    halt_cycles(20);

    // Reset in the middle of a store with mem_ready high
    do_reset();
    step(P_FETCH, 1'b1, "fetch_done");
    instr = 32'hAD2A0010;
    model_cnt = model_cnt + 1;
    step(P_DECODE, rnd(), "decode");
    step(P_ADDR, rnd(), "sw_addr");
    mem_ready = 1;
    #1;
    check("mwr_we_before_rst", {31'd0, mem_we}, 32'd1);
    rst = 1;
    #1;
    check("mwr_we_in_rst", {31'd0, mem_we}, 32'd0);
    check("mwr_req_in_rst", {31'd0, mem_req}, 32'd0);
    @(negedge clk);
    check("mwr_count_in_rst", instr_count, 32'd0);
    @(posedge clk);
    #1;
    rst = 0;
    model_cnt = 0;
    check("count_after_rst", instr_count, 32'd0);
    step(P_RSTPC, 1'b1, "rst_pc");
    run_instr(32'h2108FFFF, 0, 0, h);   // addi after recovery
    check("count_after_recover", instr_count, 32'd1);

    @(negedge clk);
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
